// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin arbiter in front of a single-port ram
//
// Purpose:
//   Shares one single-port ram between two requesters. The ram has a sync write on enable,
//   a registered read with 1-cycle latency, and read-before-write behaviour.
//   Each access takes three cycles: IDLE (grant and latch), ISSUE (drive ram), RESP (ack).
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   req0/req1                 access request, held until the matching ack
//   we0/we1                   1 = write, 0 = read
//   addr0/addr1               access address
//   wdata0/wdata1             write data
//   ack0/ack1                 one-cycle completion pulse
//   rd_data                   ram read data, valid in the ack cycle
//   busy                      high whenever the sequencer is not idle
//   ram_enable                ram write strobe
//   ram_address, ram_data_in  ram address / write data, always from the latched request
//   ram_data_out              ram registered read data
module ram_arbiter #(
  parameter int ADDRESS_BITS = 6,
  parameter int DATA_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [ADDRESS_BITS-1:0] addr0,
  input  logic [ADDRESS_BITS-1:0] addr1,
  input  logic [DATA_BITS-1:0]    wdata0,
  input  logic [DATA_BITS-1:0]    wdata1,
  output logic                    ack0,
  output logic                    ack1,
  output logic [DATA_BITS-1:0]    rd_data,
  output logic                    busy,
  output logic                    ram_enable,
  output logic [ADDRESS_BITS-1:0] ram_address,
  output logic [DATA_BITS-1:0]    ram_data_in,
  input  logic [DATA_BITS-1:0]    ram_data_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    last_owner_q, last_owner_d;
  logic                    owner_q, owner_d;
  logic                    we_q, we_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0]    wdata_q, wdata_d;

  logic any_req;
  logic winner;

  // On a tie the requester that was not granted last wins; otherwise the lone requester wins.
  assign any_req = req0 | req1;
  assign winner  = (req0 & req1) ? ~last_owner_q : req1;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      S_IDLE: begin
        // Requester inputs are only sampled here, so changes during ISSUE/RESP are ignored.
        if (any_req) begin
          state_d      = S_ISSUE;
          owner_d      = winner;
          last_owner_d = winner;
          we_d         = winner ? we1    : we0;
          addr_d       = winner ? addr1  : addr0;
          wdata_d      = winner ? wdata1 : wdata0;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // The ram samples address/data at the end of ISSUE, so its registered output is the
  // pre-access contents of the address during RESP (old value for a write).
  assign busy        = (state_q != S_IDLE);
  assign ram_enable  = (state_q == S_ISSUE) && we_q;
  assign ram_address = addr_q;
  assign ram_data_in = wdata_q;
  assign ack0        = (state_q == S_RESP) && !owner_q;
  assign ack1        = (state_q == S_RESP) &&  owner_q;
  assign rd_data     = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a behavioural ram and reference model
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [5:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy, ram_enable;
  logic [7:0] rd_data, ram_data_in, ram_data_out;
  logic [5:0] ram_address;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain memory image plus the id of the last granted requester.
  logic [7:0] ref_mem [64];
  int         m_last;

  // Behavioural single-port ram: registered read, read-before-write, write on enable.
  logic [7:0] ram_mem [64] = '{default: 8'h00};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_data_out <= ram_mem[ram_address];
    if (ram_enable) ram_mem[ram_address] <= ram_data_in;
  end

  ram_arbiter #(.ADDRESS_BITS(6), .DATA_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .ack0         (ack0),
    .ack1         (ack1),
    .rd_data      (rd_data),
    .busy         (busy),
    .ram_enable   (ram_enable),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  task automatic drive_port(input int p, input logic r, input logic w, input logic [5:0] a,
                            input logic [7:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // Runs one lone access and reports what was observed; callers judge the result.
  task automatic serve_single(input int p, input logic w, input logic [5:0] a, input logic [7:0] d,
                              output int lat, output logic [7:0] rd, output int en_cnt,
                              output int bad);
    lat = -1; rd = '0; en_cnt = 0; bad = 0;
    drive_port(p, 1'b1, w, a, d);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ram_enable) en_cnt++;
      if (ack0 && ack1) bad++;
      if ((p == 0 && ack1) || (p == 1 && ack0)) bad++;
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        lat = k;
        rd  = rd_data;
        break;
      end
    end
    drive_port(p, 1'b0, w, a, d);
    @(negedge clk);
    if (busy) bad++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd9; wdata0 = 8'h5A;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack0, ack1, busy, ram_enable} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {ack0, ack1, busy, ram_enable});
    end
    checks++;
    if ({ram_address, ram_data_in} !== 14'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0", {ram_address, ram_data_in});
    end
    req0 = 1'b0;
    rst  = 1'b0;
    m_last = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_write_read();
    int lat, en, bad;
    logic [7:0] rd;
    serve_single(0, 1'b1, 6'd5, 8'hA5, lat, rd, en, bad);
    checks++;
    if (lat !== 2 || en !== 1 || bad !== 0) begin
      failures++;
      $display("FAIL wr5 lat/en/bad got=%0d/%0d/%0d exp=2/1/0", lat, en, bad);
    end
    ref_mem[5] = 8'hA5; m_last = 0;
    serve_single(0, 1'b0, 6'd5, 8'h00, lat, rd, en, bad);
    checks++;
    if (lat !== 2 || en !== 0 || bad !== 0 || rd !== 8'hA5) begin
      failures++;
      $display("FAIL rd5 lat/en/bad/rd got=%0d/%0d/%0d/%h exp=2/0/0/a5", lat, en, bad, rd);
    end
  endtask

  task automatic test_write_old_new();
    int lat, en, bad;
    logic [7:0] rd;
    serve_single(1, 1'b1, 6'd7, 8'h11, lat, rd, en, bad);
    ref_mem[7] = 8'h11; m_last = 1;
    serve_single(0, 1'b1, 6'd7, 8'h22, lat, rd, en, bad);
    checks++;
    if (rd !== 8'h11 || lat !== 2 || en !== 1) begin
      failures++;
      $display("FAIL wr7_old rd/lat/en got=%h/%0d/%0d exp=11/2/1", rd, lat, en);
    end
    ref_mem[7] = 8'h22; m_last = 0;
    serve_single(1, 1'b0, 6'd7, 8'h00, lat, rd, en, bad);
    checks++;
    if (rd !== 8'h22 || bad !== 0) begin
      failures++;
      $display("FAIL rd7_new rd/bad got=%h/%0d exp=22/0", rd, bad);
    end
    m_last = 1;
  endtask

  task automatic test_random_fill();
    int lat, en, bad, p;
    logic [7:0] rd, d;
    int errs = 0;
    for (int a = 0; a < 64; a++) begin
      p = int'($urandom_range(0, 1));
      d = 8'($urandom);
      serve_single(p, 1'b1, 6'(a), d, lat, rd, en, bad);
      if (lat != 2 || en != 1 || bad != 0 || rd !== ref_mem[a]) begin
        errs++;
        if (errs < 4)
          $display("FAIL fill addr=%0d lat/en/bad/rd got=%0d/%0d/%0d/%h exp=2/1/0/%h",
                   a, lat, en, bad, rd, ref_mem[a]);
      end
      ref_mem[a] = d;
      m_last = p;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL fill_total errors got=%0d exp=0", errs);
    end
  endtask

  task automatic test_pairs();
    int lat, en, bad, first, t0, t1, both_hi;
    logic [7:0] rd, rd0, rd1, d0, d1, exp0, exp1;
    logic [5:0] a0, a1;
    logic w0, w1;
    for (int r = 0; r < 4; r++) begin
      if (r == 2) begin
        a0 = 6'($urandom);
        serve_single(0, 1'b0, a0, 8'h00, lat, rd, en, bad);
        checks++;
        if (rd !== ref_mem[a0] || lat !== 2) begin
          failures++;
          $display("FAIL pair_single rd/lat got=%h/%0d exp=%h/2", rd, lat, ref_mem[a0]);
        end
        m_last = 0;
      end
      w0 = 1'($urandom); a0 = 6'($urandom); d0 = 8'($urandom);
      w1 = 1'($urandom); a1 = 6'($urandom); d1 = 8'($urandom);
      first = (m_last == 1) ? 0 : 1;
      t0 = -1; t1 = -1; both_hi = 0; rd0 = '0; rd1 = '0;
      drive_port(0, 1'b1, w0, a0, d0);
      drive_port(1, 1'b1, w1, a1, d1);
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (ack0 && ack1) both_hi++;
        if (ack0 && t0 < 0) begin t0 = k; rd0 = rd_data; req0 = 1'b0; end
        if (ack1 && t1 < 0) begin t1 = k; rd1 = rd_data; req1 = 1'b0; end
        if (t0 >= 0 && t1 >= 0) break;
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      if (first == 0) begin
        exp0 = ref_mem[a0]; if (w0) ref_mem[a0] = d0;
        exp1 = ref_mem[a1]; if (w1) ref_mem[a1] = d1;
        m_last = 1;
      end else begin
        exp1 = ref_mem[a1]; if (w1) ref_mem[a1] = d1;
        exp0 = ref_mem[a0]; if (w0) ref_mem[a0] = d0;
        m_last = 0;
      end
      checks++;
      if (t0 != ((first == 0) ? 2 : 5) || t1 != ((first == 1) ? 2 : 5) || both_hi != 0) begin
        failures++;
        $display("FAIL pair%0d timing t0/t1/both got=%0d/%0d/%0d first=%0d", r, t0, t1, both_hi,
                 first);
      end
      checks++;
      if (rd0 !== exp0 || rd1 !== exp1) begin
        failures++;
        $display("FAIL pair%0d data rd0/rd1 got=%h/%h exp=%h/%h", r, rd0, rd1, exp0, exp1);
      end
    end
  endtask

  task automatic test_interleave();
    int seq[$];
    int n_acks = 0, raise0 = 0, first_exp;
    bit rearm = 1'b0;
    logic [5:0] a0, a1;
    logic [7:0] d0, ex;
    logic w0;
    first_exp = (m_last == 1) ? 0 : 1;
    a1 = 6'($urandom);
    w0 = 1'($urandom); a0 = 6'($urandom); d0 = 8'($urandom);
    drive_port(1, 1'b1, 1'b0, a1, 8'h00);
    drive_port(0, 1'b1, w0, a0, d0);
    for (int n = 1; n <= 60 && n_acks < 8; n++) begin
      @(negedge clk);
      checks++;
      if (ack0 && ack1) begin
        failures++;
        $display("FAIL ilv both_acks got=11 exp=not both");
      end
      if (ack0) begin
        ex = ref_mem[a0];
        if (w0) ref_mem[a0] = d0;
        checks++;
        if (rd_data !== ex) begin
          failures++;
          $display("FAIL ilv rd0 got=%h exp=%h", rd_data, ex);
        end
        checks++;
        if (n - raise0 > 5) begin
          failures++;
          $display("FAIL ilv wait0 got=%0d exp<=5", n - raise0);
        end
        seq.push_back(0);
        n_acks++;
        req0  = 1'b0;
        rearm = 1'b1;
      end else if (rearm) begin
        w0 = 1'($urandom); a0 = 6'($urandom); d0 = 8'($urandom);
        drive_port(0, 1'b1, w0, a0, d0);
        raise0 = n;
        rearm  = 1'b0;
      end
      if (ack1) begin
        checks++;
        if (rd_data !== ref_mem[a1]) begin
          failures++;
          $display("FAIL ilv rd1 got=%h exp=%h", rd_data, ref_mem[a1]);
        end
        seq.push_back(1);
        n_acks++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (n_acks != 8) begin
      failures++;
      $display("FAIL ilv ack_count got=%0d exp=8", n_acks);
    end
    if (seq.size() > 0) begin
      checks++;
      if (seq[0] != first_exp) begin
        failures++;
        $display("FAIL ilv first_grant got=%0d exp=%0d", seq[0], first_exp);
      end
      for (int i = 1; i < seq.size(); i++) begin
        checks++;
        if (seq[i] == seq[i-1]) begin
          failures++;
          $display("FAIL ilv alternate idx=%0d got=%0d exp=%0d", i, seq[i], 1 - seq[i-1]);
        end
      end
      m_last = seq[seq.size()-1];
    end
  endtask

  task automatic test_reset_mid();
    int lat, en, bad, stray = 0;
    logic [7:0] rd;
    logic [5:0] a;
    a = 6'($urandom);
    drive_port(1, 1'b1, 1'b0, a, 8'h00);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid issue_busy got=%b exp=1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, ack1, ack0, ram_enable} !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid after got=%b exp=0000", {busy, ack1, ack0, ram_enable});
    end
    rst = 1'b0;
    req1 = 1'b0;
    m_last = 1;
    repeat (3) begin
      @(negedge clk);
      if (ack0 || ack1 || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL rstmid stray_activity got=%0d exp=0", stray);
    end
    serve_single(1, 1'b0, a, 8'h00, lat, rd, en, bad);
    checks++;
    if (rd !== ref_mem[a] || lat !== 2 || bad !== 0) begin
      failures++;
      $display("FAIL rstmid reissue rd/lat/bad got=%h/%0d/%0d exp=%h/2/0", rd, lat, bad, ref_mem[a]);
    end
    m_last = 1;
  endtask

  task automatic test_hold_inputs();
    int lat, en, bad;
    logic [7:0] rd, d, dd;
    d = 8'($urandom);
    drive_port(0, 1'b1, 1'b1, 6'd3, d);
    @(negedge clk);
    checks++;
    if ({ram_enable, ram_address, ram_data_in} !== {1'b1, 6'd3, d}) begin
      failures++;
      $display("FAIL hold issue en/addr/data got=%b/%0d/%h exp=1/3/%h", ram_enable, ram_address,
               ram_data_in, d);
    end
    addr0  = 6'd60;
    wdata0 = ~d;
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b1 || rd_data !== ref_mem[3]) begin
      failures++;
      $display("FAIL hold resp ack/rd got=%b/%h exp=1/%h", ack0, rd_data, ref_mem[3]);
    end
    req0 = 1'b0;
    ref_mem[3] = d;
    m_last = 0;
    @(negedge clk);
    serve_single(1, 1'b0, 6'd3, 8'h00, lat, rd, en, bad);
    checks++;
    if (rd !== d) begin
      failures++;
      $display("FAIL hold readback3 got=%h exp=%h", rd, d);
    end
    serve_single(0, 1'b0, 6'd60, 8'h00, lat, rd, en, bad);
    checks++;
    if (rd !== ref_mem[60]) begin
      failures++;
      $display("FAIL hold addr60_untouched got=%h exp=%h", rd, ref_mem[60]);
    end
    dd = 8'($urandom);
    serve_single(1, 1'b1, 6'd63, dd, lat, rd, en, bad);
    checks++;
    if (rd !== ref_mem[63] || en !== 1) begin
      failures++;
      $display("FAIL max_addr write old/en got=%h/%0d exp=%h/1", rd, en, ref_mem[63]);
    end
    ref_mem[63] = dd;
    serve_single(0, 1'b0, 6'd63, 8'h00, lat, rd, en, bad);
    checks++;
    if (rd !== dd) begin
      failures++;
      $display("FAIL max_addr readback got=%h exp=%h", rd, dd);
    end
    serve_single(1, 1'b0, 6'd0, 8'h00, lat, rd, en, bad);
    checks++;
    if (rd !== ref_mem[0]) begin
      failures++;
      $display("FAIL max_addr no_wrap addr0 got=%h exp=%h", rd, ref_mem[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    m_last = 1;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_write_old_new();
    test_random_fill();
    test_pairs();
    test_interleave();
    test_reset_mid();
    test_hold_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
